// File: rtl/alu_rs_unit.sv
// Integer ALU functional unit: NUM_RS reservation stations, one multi-cycle ALU and a result buffer on the CDB.
// Define ALU_RS_SLT_EN to make opcode 010 a legal signed set-less-than.
module alu_rs_unit #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 6,
    parameter int NUM_RS   = 3,
    parameter int BASE_TAG = 1,
    parameter int EXEC_LAT = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue,
    input  logic [2:0]        opcode,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              A_invalid,
    input  logic              B_invalid,
    output logic              available,
    output logic [TAG_W-1:0]  RS_available,
    output logic [TAG_W-1:0]  issued,
    output logic              error,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              CDB_rts,
    output logic [TAG_W-1:0]  CDB_source,
    output logic [DATA_W-1:0] CDB_data,
    input  logic              CDB_xmit,
    output logic [TAG_W-1:0]  RS_executing
);

    localparam int IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

    logic [NUM_RS-1:0] busy;
    logic [NUM_RS-1:0] dispatched;
    logic [NUM_RS-1:0] ready;
    logic [2:0]        op_rs [NUM_RS];
    logic [DATA_W-1:0] vj [NUM_RS];
    logic [DATA_W-1:0] vk [NUM_RS];
    logic [TAG_W-1:0]  qj [NUM_RS];
    logic [TAG_W-1:0]  qk [NUM_RS];

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  exec_idx;
    logic [2:0]        op_p1;
    logic [DATA_W-1:0] vj_p1;
    logic [DATA_W-1:0] vk_p1;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  cand;
    logic [IDX_W-1:0]  rr_next;
    logic              legal;

    function automatic logic [TAG_W-1:0] rs_tag(input logic [IDX_W-1:0] idx);
        return TAG_W'(BASE_TAG) + TAG_W'(idx);
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        logic ok;
        case (op)
            3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111: ok = 1'b1;
`ifdef ALU_RS_SLT_EN
            3'b010: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [DATA_W-1:0] alu_calc(input logic [2:0] op,
                                                   input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] r;
        case (op)
            3'b000: r = a + b;
            3'b001: r = a - b;
            3'b100: r = a | b;
            3'b101: r = a & b;
            3'b110: r = ~a;
            3'b111: r = a ^ b;
`ifdef ALU_RS_SLT_EN
            3'b010: r = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    assign legal = op_legal(opcode);

    // Lowest free station; loop runs downward so the smallest index wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    assign available    = free_found;
    assign RS_available = free_found ? rs_tag(free_idx) : '0;

    always_comb begin
        for (int i = 0; i < NUM_RS; i++) begin
            ready[i] = busy[i] && !dispatched[i] && (qj[i] == '0) && (qk[i] == '0);
        end
    end

    // Round-robin: first ready station at or after rr_ptr, wrapping at NUM_RS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_RS - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NUM_RS);
            if (ready[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign rr_next = (pick_idx == IDX_W'(NUM_RS - 1)) ? '0 : pick_idx + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy         <= '0;
            dispatched   <= '0;
            for (int i = 0; i < NUM_RS; i++) begin
                op_rs[i] <= '0;
                vj[i]    <= '0;
                vk[i]    <= '0;
                qj[i]    <= '0;
                qk[i]    <= '0;
            end
            state        <= IDLE;
            cnt          <= '0;
            rr_ptr       <= '0;
            exec_idx     <= '0;
            op_p1        <= '0;
            vj_p1        <= '0;
            vk_p1        <= '0;
            issued       <= '0;
            error        <= 1'b0;
            CDB_rts      <= 1'b0;
            CDB_source   <= '0;
            CDB_data     <= '0;
            RS_executing <= '0;
        end else begin
            // CDB snoop: waiting operands of busy stations capture a matching broadcast.
            for (int i = 0; i < NUM_RS; i++) begin
                if (busy[i] && cdb_valid && (cdb_tag != '0)) begin
                    if (qj[i] == cdb_tag) begin
                        vj[i] <= cdb_data;
                        qj[i] <= '0;
                    end
                    if (qk[i] == cdb_tag) begin
                        vk[i] <= cdb_data;
                        qk[i] <= '0;
                    end
                end
            end

            issued <= '0;
            error  <= 1'b0;
            if (issue) begin
                if (legal && free_found) begin
                    busy[free_idx]       <= 1'b1;
                    dispatched[free_idx] <= 1'b0;
                    op_rs[free_idx]      <= opcode;
                    issued               <= rs_tag(free_idx);
                    vj[free_idx]         <= A;
                    qj[free_idx]         <= '0;
                    if (A_invalid) begin
                        if (cdb_valid && (cdb_tag != '0) && (cdb_tag == A[TAG_W-1:0])) begin
                            vj[free_idx] <= cdb_data;
                        end else begin
                            qj[free_idx] <= A[TAG_W-1:0];
                        end
                    end
                    vk[free_idx]         <= B;
                    qk[free_idx]         <= '0;
                    if (B_invalid && (opcode != 3'b110)) begin
                        if (cdb_valid && (cdb_tag != '0) && (cdb_tag == B[TAG_W-1:0])) begin
                            vk[free_idx] <= cdb_data;
                        end else begin
                            qk[free_idx] <= B[TAG_W-1:0];
                        end
                    end
                end else begin
                    error <= 1'b1;
                end
            end

            // Dispatch -> execute -> hold result until the arbiter grants the bus.
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        op_p1                <= op_rs[pick_idx];
                        vj_p1                <= vj[pick_idx];
                        vk_p1                <= vk[pick_idx];
                        cnt                  <= CNT_W'(EXEC_LAT - 1);
                        exec_idx             <= pick_idx;
                        dispatched[pick_idx] <= 1'b1;
                        RS_executing         <= rs_tag(pick_idx);
                        rr_ptr               <= rr_next;
                        state                <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        CDB_data   <= alu_calc(op_p1, vj_p1, vk_p1);
                        CDB_source <= rs_tag(exec_idx);
                        CDB_rts    <= 1'b1;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (CDB_xmit) begin
                        CDB_rts              <= 1'b0;
                        busy[exec_idx]       <= 1'b0;
                        dispatched[exec_idx] <= 1'b0;
                        RS_executing         <= '0;
                        state                <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rs_unit.sv
// Directed bench for alu_rs_unit: expected CDB results are queued at issue and matched by a negedge monitor.
module tb_alu_rs_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        issue;
    logic [2:0]  opcode;
    logic [31:0] A, B;
    logic        A_invalid, B_invalid;
    logic        available;
    logic [5:0]  RS_available;
    logic [5:0]  issued;
    logic        error;
    logic        cdb_valid;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        CDB_rts;
    logic [5:0]  CDB_source;
    logic [31:0] CDB_data;
    logic        CDB_xmit;
    logic [5:0]  RS_executing;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] obs[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clock = ~clock;

    alu_rs_unit dut (
        .clock(clock), .reset_n(reset_n), .issue(issue), .opcode(opcode),
        .A(A), .B(B), .A_invalid(A_invalid), .B_invalid(B_invalid),
        .available(available), .RS_available(RS_available), .issued(issued), .error(error),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .CDB_rts(CDB_rts), .CDB_source(CDB_source), .CDB_data(CDB_data),
        .CDB_xmit(CDB_xmit), .RS_executing(RS_executing)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_issue(input logic [2:0] op, input logic [31:0] a, input logic ainv,
                            input logic [31:0] b, input logic binv, input logic [5:0] exp_tag,
                            input logic exp_err, input logic push, input logic [31:0] exp_res);
        if (push) sb.push_back('{tag: exp_tag, data: exp_res});
        issue = 1'b1; opcode = op; A = a; A_invalid = ainv; B = b; B_invalid = binv;
        tick();
        issue = 1'b0; A_invalid = 1'b0; B_invalid = 1'b0;
        check("issued", 32'(issued), 32'(exp_tag));
        check("error", 32'(error), 32'(exp_err));
    endtask

    task automatic wait_sb(input int n, input int budget);
        int c = 0;
        while (sb.size() > n && c < budget) begin
            tick();
            c++;
        end
        check("sb_drain", sb.size(), n);
    endtask

    task automatic wait_rts(input int budget);
        int c = 0;
        while (!CDB_rts && c < budget) begin
            tick();
            c++;
        end
        check("rts_reached", 32'(CDB_rts), 1);
    endtask

    // Transfer happens at the next rising edge whenever rts and xmit are both high here.
    always @(negedge clock) begin
        if (reset_n && CDB_rts && CDB_xmit) begin
            int hit;
            hit = -1;
            for (int i = sb.size() - 1; i >= 0; i--)
                if (sb[i].tag == CDB_source) hit = i;
            obs.push_back(CDB_source);
            if (hit < 0) begin
                checks++;
                errors++;
                $display("FAIL cdb_source: got %0d, no result with that tag pending", CDB_source);
            end else begin
                check("cdb_data", CDB_data, sb[hit].data);
                sb.delete(hit);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] exp_order [4];
        exp_order[0] = 6'd1; exp_order[1] = 6'd2; exp_order[2] = 6'd3; exp_order[3] = 6'd1;
        reset_n = 1'b0; issue = 1'b0; opcode = '0; A = '0; B = '0;
        A_invalid = 1'b0; B_invalid = 1'b0; cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        CDB_xmit = 1'b0;
        tick(); tick();
        check("rst_available", 32'(available), 1);
        check("rst_rs_available", 32'(RS_available), 1);
        check("rst_issued", 32'(issued), 0);
        check("rst_error", 32'(error), 0);
        check("rst_rts", 32'(CDB_rts), 0);
        check("rst_source", 32'(CDB_source), 0);
        check("rst_data", CDB_data, 0);
        check("rst_executing", 32'(RS_executing), 0);
        reset_n = 1'b1;
        tick();

        // T1: latency and hand-off of a simple add
        do_issue(3'b000, 5, 0, 7, 0, 1, 0, 1, 12);
        check("t1_rts_e0", 32'(CDB_rts), 0);
        tick();
        check("t1_rts_e1", 32'(CDB_rts), 0);
        check("t1_exec", 32'(RS_executing), 1);
        tick();
        check("t1_rts_e2", 32'(CDB_rts), 0);
        tick();
        check("t1_rts_e3", 32'(CDB_rts), 1);
        check("t1_source", 32'(CDB_source), 1);
        check("t1_data", CDB_data, 12);
        CDB_xmit = 1'b1;
        tick();
        check("t1_rts_drop", 32'(CDB_rts), 0);
        check("t1_exec_idle", 32'(RS_executing), 0);
        check("t1_rs_avail", 32'(RS_available), 1);

        // T2: operand arrives by snoop two cycles after issue
        do_issue(3'b001, 9, 1, 3, 0, 1, 0, 1, 7);
        tick();
        check("t2_waiting", 32'(RS_executing), 0);
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 10;
        tick();
        cdb_valid = 1'b0;
        check("t2_snoop_edge", 32'(RS_executing), 0);
        tick();
        check("t2_dispatch", 32'(RS_executing), 1);
        wait_sb(0, 20);

        // T3: operand forwarded from the CDB on the issue edge
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 4;
        do_issue(3'b100, 9, 1, 1, 0, 1, 0, 1, 5);
        cdb_valid = 1'b0;
        tick();
        check("t3_dispatch", 32'(RS_executing), 1);
        wait_sb(0, 20);

        // T4: full stations, rejected issue, result held while grant is low
        CDB_xmit = 1'b0;
        do_issue(3'b000, 1, 0, 2, 0, 1, 0, 1, 3);
        do_issue(3'b111, 32'hF0, 0, 32'hFF, 0, 2, 0, 1, 32'h0F);
        do_issue(3'b110, 0, 0, 5, 1, 3, 0, 1, 32'hFFFF_FFFF);
        do_issue(3'b000, 1, 0, 1, 0, 0, 1, 0, 0);
        check("t4_available", 32'(available), 0);
        check("t4_rs_available", 32'(RS_available), 0);
        for (int i = 0; i < 10; i++) begin
            check("t4_hold_rts", 32'(CDB_rts), 1);
            check("t4_hold_source", 32'(CDB_source), 1);
            check("t4_hold_data", CDB_data, 3);
            tick();
        end
        check("t4_error_pulse", 32'(error), 0);
        CDB_xmit = 1'b1;
        wait_sb(0, 100);
        check("t4_available_after", 32'(available), 1);
        check("t4_rs_avail_after", 32'(RS_available), 1);

        // T5: round-robin order, wrap past the last station, add overflow wrap
        obs.delete();
        do_issue(3'b000, 32'h7FFF_FFFF, 0, 1, 0, 1, 0, 1, 32'h8000_0000);
        do_issue(3'b100, 32'hF0, 0, 32'h0F, 0, 2, 0, 1, 32'hFF);
        do_issue(3'b101, 22, 1, 32'hFF, 0, 3, 0, 1, 32'h34);
        wait_sb(1, 50);
        cdb_valid = 1'b1; cdb_tag = 6'd22; cdb_data = 32'h1234;
        do_issue(3'b111, 32'hA5, 0, 32'h0F, 0, 1, 0, 1, 32'hAA);
        cdb_valid = 1'b0;
        wait_sb(0, 50);
        check("t5_obs_count", obs.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t5_order", 32'((i < obs.size()) ? obs[i] : 6'd0), 32'(exp_order[i]));

        // T6: reset during WAIT aborts; illegal opcodes rejected
        CDB_xmit = 1'b0;
        do_issue(3'b000, 2, 0, 2, 0, 1, 0, 0, 0);
        wait_rts(20);
        reset_n = 1'b0;
        tick();
        check("t6_rts", 32'(CDB_rts), 0);
        check("t6_available", 32'(available), 1);
        check("t6_rs_available", 32'(RS_available), 1);
        check("t6_executing", 32'(RS_executing), 0);
        reset_n = 1'b1;
        do_issue(3'b010, 1, 0, 1, 0, 0, 1, 0, 0);
        check("t6_no_alloc", 32'(RS_available), 1);
        tick();
        check("t6_error_clear", 32'(error), 0);
        do_issue(3'b011, 1, 0, 1, 0, 0, 1, 0, 0);
        CDB_xmit = 1'b1;
        do_issue(3'b001, 0, 0, 1, 0, 1, 0, 1, 32'hFFFF_FFFF);
        do_issue(3'b101, 32'hF0F0, 0, 32'hFF00, 0, 2, 0, 1, 32'hF000);
        wait_sb(0, 50);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
